// File: rtl/decoder_3to8_stream.sv
// decoder_3to8_stream: buffers {en, code} entries from the priority encoder
// in a small FIFO. Each decoded one-hot word is shown on out_onehot for
// DWELL cycles.
// Optional build macro DECODER_OUT_ACTIVE_LOW_EN inverts out_onehot for
// active-low LED drive. Idle and reset value becomes 8'hFF in that build.
module decoder_3to8_stream #(
  parameter int FIFO_DEPTH = 4,
  parameter int DWELL      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_en,
  input  logic [2:0]                    in_code,
  output logic [7:0]                    out_onehot,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(DWELL) + 1;

`ifdef DECODER_OUT_ACTIVE_LOW_EN
  localparam logic [7:0] POL = 8'hFF;
`else
  localparam logic [7:0] POL = 8'h00;
`endif
  localparam logic [7:0] IDLE_WORD = POL;

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  // One-hot decode with output polarity applied; en=0 gives the blank word.
  function automatic logic [7:0] f_decode(input logic en, input logic [2:0] code);
    logic [7:0] w;
    w = en ? (8'b1 << code) : 8'h00;
    return w ^ POL;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [7:0]      r_onehot, w_onehot_nxt;
  logic            r_valid, w_valid_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic            w_full, w_empty, w_push, w_pop;
  logic [3:0]      w_head;

  // Push is gated on full before any same-cycle pop.
  assign w_full   = (r_level == LW'(FIFO_DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr];

  assign in_ready   = !w_full;
  assign fifo_level = r_level;
  assign out_onehot = r_onehot;
  assign out_valid  = r_valid;
  assign busy       = (r_state == S_SHOW) || !w_empty;

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_en, in_code};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Next-state and display logic: load a word when idle or when a dwell expires.
  always_comb begin
    w_state_nxt  = r_state;
    w_onehot_nxt = r_onehot;
    w_valid_nxt  = r_valid;
    w_timer_nxt  = r_timer;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt  = 1'b0;
        w_onehot_nxt = IDLE_WORD;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_onehot_nxt = f_decode(w_head[3], w_head[2:0]);
          w_valid_nxt  = 1'b1;
          w_timer_nxt  = TW'(DWELL - 1);
          w_state_nxt  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - TW'(1);
        end else if (!w_empty) begin
          // Back-to-back: next entry replaces the current one with no gap.
          w_pop        = 1'b1;
          w_onehot_nxt = f_decode(w_head[3], w_head[2:0]);
          w_valid_nxt  = 1'b1;
          w_timer_nxt  = TW'(DWELL - 1);
        end else begin
          w_valid_nxt  = 1'b0;
          w_onehot_nxt = IDLE_WORD;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_valid_nxt  = 1'b0;
        w_onehot_nxt = IDLE_WORD;
        w_timer_nxt  = '0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  // State and output registers; outputs come straight from these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_onehot <= IDLE_WORD;
      r_valid  <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_onehot <= w_onehot_nxt;
      r_valid  <= w_valid_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_3to8_stream.sv
// Bench for decoder_3to8_stream: directed steps plus random traffic.
// The reference is a display timeline. An entry accepted at edge t starts
// showing at max(t+1, end of the previous entry). It covers DWELL edges.
// Occupancy is the number of accepted entries whose start is still ahead.
module tb_decoder_3to8_stream;
  localparam int DEPTH = 4;
  localparam int DW    = 4;
`ifdef DECODER_OUT_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic       clk, rst_n, in_valid, in_ready, in_en, out_valid, busy;
  logic [2:0] in_code, fifo_level;
  logic [7:0] out_onehot;

  decoder_3to8_stream #(.FIFO_DEPTH(DEPTH), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_en(in_en), .in_code(in_code), .out_onehot(out_onehot),
    .out_valid(out_valid), .fifo_level(fifo_level), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         fails  = 0;
  int         e      = 0;
  int         prev_end = 0;
  int         st_q[$];
  logic [7:0] wd_q[$];

  function automatic int m_level();
    int c = 0;
    foreach (st_q[i]) if (st_q[i] > e) c++;
    return c;
  endfunction

  function automatic logic m_show();
    foreach (st_q[i]) if (st_q[i] <= e && e < st_q[i] + DW) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_word();
    foreach (st_q[i]) if (st_q[i] <= e && e < st_q[i] + DW) return wd_q[i];
    return INV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("onehot", {24'd0, out_onehot}, {24'd0, m_word()});
    chk("valid",  {31'd0, out_valid},  {31'd0, m_show()});
    chk("level",  {29'd0, fifo_level}, m_level());
    chk("ready",  {31'd0, in_ready},   {31'd0, m_level() < DEPTH});
    chk("busy",   {31'd0, busy},       {31'd0, m_show() || m_level() != 0});
  endtask

  // Called at a negedge: check, drive the next cycle, advance one edge.
  task automatic step(input logic v, input logic en, input logic [2:0] code, output logic acc);
    int s;
    logic [7:0] w;
    check_all();
    in_valid = v; in_en = en; in_code = code;
    acc = v && (m_level() < DEPTH);
    @(posedge clk);
    e++;
    if (acc) begin
      s = (e + 1 > prev_end) ? e + 1 : prev_end;
      prev_end = s + DW;
      w = en ? (8'b1 << code) : 8'h00;
      st_q.push_back(s);
      wd_q.push_back(w ^ INV);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, acc);
  endtask

  task automatic push_hold(input logic en, input logic [2:0] code);
    logic acc;
    int   n = 0;
    do begin
      step(1'b1, en, code, acc);
      n++;
    end while (!acc && n < 40);
    chk("hold_accept", {31'd0, acc}, 32'd1);
  endtask

  // Asynchronous reset asserted mid-cycle; checked before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    st_q.delete(); wd_q.delete(); prev_end = 0;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
    logic v;
    rst_n = 1'b1; in_valid = 1'b0; in_en = 1'b0; in_code = 3'd0;
    @(negedge clk);
    do_reset();
    idle(2);
    // single entry en=1 code=5
    push_hold(1'b1, 3'd5);
    idle(1);
    chk("single_word", {24'd0, out_onehot}, {24'd0, 8'h20 ^ INV});
    idle(7);
    // disabled entry still dwells with out_valid=1
    push_hold(1'b0, 3'd3);
    idle(1);
    chk("disabled_valid", {31'd0, out_valid}, 32'd1);
    idle(7);
    // burst into a full FIFO, back-to-back display
    for (int c = 0; c < 5; c++) push_hold(1'b1, 3'(c));
    idle(24);
    // reset while 8'h04 is shown with two entries queued
    push_hold(1'b1, 3'd2);
    push_hold(1'b1, 3'd3);
    push_hold(1'b1, 3'd4);
    chk("pre_rst_word", {24'd0, out_onehot}, {24'd0, 8'h04 ^ INV});
    chk("pre_rst_level", {29'd0, fifo_level}, 32'd2);
    do_reset();
    idle(12);
    // random traffic: dense phase, a random reset, then sparse phase
    for (int i = 0; i < 400; i++) begin
      if (i == 250) do_reset();
      v = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      step(v, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), acc);
    end
    idle(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
